uart_alu_interface: RTL and testbench
=====================================

Name: uart_alu_interface

Overview:
- Sequencing stage between the UART receiver/transmitter and the ALU; it replaces the manual switch/button loading of the ALU.
- Collects three received bytes in order: operand A, operand B, opcode. Drives them to the ALU, captures the combinational ALU result and hands it to the UART transmitter with a one-cycle start pulse.
- Single clock domain, purely sequential control; contains no arithmetic of its own.

Parameters:
N_BITS_DATA, 8, width of UART bytes, ALU operands and ALU result
N_BITS_OP, 6, width of ALU opcode (low bits of the received opcode byte)

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst  input  1  reset, synchronous, active-low (0 = reset)
i_rx_data  input  N_BITS_DATA  byte from UART receiver, valid when i_rx_done=1
i_rx_done  input  1  one-cycle pulse: new received byte
i_alu_result  input  N_BITS_DATA  combinational ALU output for current o_alu_A/B/Op
i_tx_done  input  1  one-cycle pulse: transmitter finished current byte
o_alu_A  output  N_BITS_DATA  registered operand A
o_alu_B  output  N_BITS_DATA  registered operand B
o_alu_Op  output  N_BITS_OP  registered opcode
o_tx_data  output  N_BITS_DATA  registered byte to transmit
o_tx_start  output  1  one-cycle pulse: start transmission of o_tx_data
o_busy  output  1  1 while in SEND or WAIT_TX
o_rx_overrun  output  1  sticky: a byte arrived while busy and was dropped

Behaviour:
- Reset (i_rst=0 at a rising edge): state=WAIT_A; o_alu_A=0, o_alu_B=0, o_alu_Op=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_rx_overrun=0. Reset has priority over every other event, including mid-transaction; any partial A/B/Op sequence is discarded.
- States and transitions:
  - WAIT_A: on i_rx_done, o_alu_A<=i_rx_data; go to WAIT_B.
  - WAIT_B: on i_rx_done, o_alu_B<=i_rx_data; go to WAIT_OP.
  - WAIT_OP: on i_rx_done, o_alu_Op<=i_rx_data[N_BITS_OP-1:0]; go to SEND. Upper opcode byte bits are ignored.
  - SEND: lasts exactly one cycle. At its closing edge: o_tx_data<=i_alu_result, o_tx_start<=1; go to WAIT_TX.
  - WAIT_TX: o_tx_start returns to 0 at the first edge in WAIT_TX, giving a single-cycle pulse. On i_tx_done go to WAIT_A.
- Without the relevant strobe, each state holds.
- Latency: the rx_done edge that latches the opcode is edge N. The SEND edge is N+1. o_tx_start is high for the cycle after edge N+1 only. The ALU result has one full cycle (SEND) to settle.
- o_busy is combinational from state: 1 in SEND and WAIT_TX.
- i_rx_done while in SEND or WAIT_TX: the byte is dropped and o_rx_overrun<=1. The flag stays set until reset. This holds even if i_tx_done occurs in the same cycle; the state still returns to WAIT_A.
- i_tx_done outside WAIT_TX is ignored.
- o_alu_A/B/Op hold their last values between transactions and are only overwritten by their own state's rx_done. The ALU output therefore stays stable during transmission.
- All widths are exact; there is no sign extension or truncation except the opcode slice.

Test Plan:
- Reset: hold i_rst=0 for 2 cycles with random rx traffic -> all outputs 0, state WAIT_A, o_busy=0.
- Basic ADD (bench ALU model, N_BITS_DATA=8): rx 0x27, 0x03, 0x20 -> o_alu_A=0x27, o_alu_B=0x03, o_alu_Op=0x20. o_tx_start pulses exactly one cycle, 2 edges after the opcode rx_done, with o_tx_data=0x2A. After i_tx_done, o_busy=0.
- Back-to-back transactions: after the ADD, rx 0x27, 0x03, 0x22 (SUB) -> o_tx_data=0x24. A second: 0x0F, 0x3C, 0x24 (AND) -> o_tx_data=0x0C. Exactly one o_tx_start per transaction.
- Overrun: rx byte 0x55 while in WAIT_TX, also coincident with i_tx_done -> byte dropped, o_rx_overrun=1 and sticky, next rx byte loads o_alu_A.
- Reset mid-sequence: rx 0x11, 0x22, then i_rst=0 for one cycle, then rx 0x05, 0x01, 0x25 (OR) -> o_tx_data=0x05, with A=0x05 taken from the post-reset byte.
- Opcode slicing: rx opcode byte 0xE0 -> o_alu_Op=0x20; spurious i_tx_done in WAIT_B -> no state change.

Source files
------------

// File: rtl/uart_alu_interface.sv
// Sequencer between UART rx/tx and the ALU: gathers A, B, opcode bytes, then
// transmits the captured ALU result with a single-cycle start pulse.
module uart_alu_interface #(
    parameter int unsigned N_BITS_DATA = 8,
    parameter int unsigned N_BITS_OP   = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_BITS_DATA-1:0] i_rx_data,
    input  logic                   i_rx_done,
    input  logic [N_BITS_DATA-1:0] i_alu_result,
    input  logic                   i_tx_done,
    output logic [N_BITS_DATA-1:0] o_alu_A,
    output logic [N_BITS_DATA-1:0] o_alu_B,
    output logic [N_BITS_OP-1:0]   o_alu_Op,
    output logic [N_BITS_DATA-1:0] o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_busy,
    output logic                   o_rx_overrun
);

    typedef enum logic [2:0] {
        StWaitA,
        StWaitB,
        StWaitOp,
        StSend,
        StWaitTx
    } state_e;

    state_e                 state_q, state_d;
    logic [N_BITS_DATA-1:0] alu_a_q, alu_a_d;
    logic [N_BITS_DATA-1:0] alu_b_q, alu_b_d;
    logic [N_BITS_OP-1:0]   alu_op_q, alu_op_d;
    logic [N_BITS_DATA-1:0] tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   overrun_q, overrun_d;
    logic                   busy;

    assign busy = (state_q == StSend) || (state_q == StWaitTx);

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        // Bytes arriving while a result is in flight are dropped, not queued.
        overrun_d  = overrun_q | (i_rx_done & busy);

        unique case (state_q)
            StWaitA: begin
                if (i_rx_done) begin
                    alu_a_d = i_rx_data;
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                if (i_rx_done) begin
                    alu_b_d = i_rx_data;
                    state_d = StWaitOp;
                end
            end
            StWaitOp: begin
                if (i_rx_done) begin
                    alu_op_d = i_rx_data[N_BITS_OP-1:0];
                    state_d  = StSend;
                end
            end
            StSend: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = StWaitTx;
            end
            StWaitTx: begin
                if (i_tx_done) begin
                    state_d = StWaitA;
                end
            end
            default: state_d = StWaitA;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= StWaitA;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_alu_A      = alu_a_q;
    assign o_alu_B      = alu_b_q;
    assign o_alu_Op     = alu_op_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_busy       = busy;
    assign o_rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench: vector table of transactions, a small ALU model and a
// scoreboard queue of expected transmit bytes, plus hand-written corner cases.
module tb_uart_alu_interface;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic [7:0] i_alu_result;
    logic       i_tx_done;
    logic [7:0] o_alu_A;
    logic [7:0] o_alu_B;
    logic [5:0] o_alu_Op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_rx_overrun;

    int total = 0;
    int bad = 0;
    int starts_seen = 0;
    int starts_exp = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [5:0] exp_op;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs[5];

    uart_alu_interface #(
        .N_BITS_DATA(8),
        .N_BITS_OP  (6)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .i_alu_result(i_alu_result),
        .i_tx_done   (i_tx_done),
        .o_alu_A     (o_alu_A),
        .o_alu_B     (o_alu_B),
        .o_alu_Op    (o_alu_Op),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_busy      (o_busy),
        .o_rx_overrun(o_rx_overrun)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Combinational ALU model driven by the DUT's operand outputs.
    always_comb begin
        i_alu_result = 8'h00;
        case (o_alu_Op)
            6'h20: i_alu_result = o_alu_A + o_alu_B;
            6'h22: i_alu_result = o_alu_A - o_alu_B;
            6'h24: i_alu_result = o_alu_A & o_alu_B;
            6'h25: i_alu_result = o_alu_A | o_alu_B;
            6'h26: i_alu_result = o_alu_A ^ o_alu_B;
            default: i_alu_result = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_tx_start === 1'b1) begin
            starts_seen++;
            if (sb.size() == 0) check("tx_start_unexpected", 32'd1, 32'd0);
            else check("tx_data", {24'd0, o_tx_data}, {24'd0, sb.pop_front()});
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        i_rx_data = d;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input logic [5:0] exp_op, input logic [7:0] exp_res);
        send_byte(a);
        check("load_A", {24'd0, o_alu_A}, {24'd0, a});
        check("busy_wait_b", {31'd0, o_busy}, 32'd0);
        send_byte(b);
        check("load_B", {24'd0, o_alu_B}, {24'd0, b});
        send_byte(op);
        sb.push_back(exp_res);
        starts_exp++;
        check("load_Op", {26'd0, o_alu_Op}, {26'd0, exp_op});
        check("busy_send", {31'd0, o_busy}, 32'd1);
        check("start_low_send", {31'd0, o_tx_start}, 32'd0);
        tick();
        check("start_high", {31'd0, o_tx_start}, 32'd1);
        check("tx_data_direct", {24'd0, o_tx_data}, {24'd0, exp_res});
        tick();
        check("start_single", {31'd0, o_tx_start}, 32'd0);
        check("busy_wait_tx", {31'd0, o_busy}, 32'd1);
        check("A_stable_tx", {24'd0, o_alu_A}, {24'd0, a});
        pulse_tx_done();
        check("busy_after_done", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{a: 8'h27, b: 8'h03, op: 8'h20, exp_op: 6'h20, exp_res: 8'h2A};
        vecs[1] = '{a: 8'h27, b: 8'h03, op: 8'h22, exp_op: 6'h22, exp_res: 8'h24};
        vecs[2] = '{a: 8'h0F, b: 8'h3C, op: 8'h24, exp_op: 6'h24, exp_res: 8'h0C};
        vecs[3] = '{a: 8'h10, b: 8'h05, op: 8'hE0, exp_op: 6'h20, exp_res: 8'h15};
        vecs[4] = '{a: 8'hF0, b: 8'h3C, op: 8'h26, exp_op: 6'h26, exp_res: 8'hCC};

        i_rst = 1'b0;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;

        // Reset with random traffic on the strobes.
        for (int i = 0; i < 2; i++) begin
            i_rx_done = 1'($urandom_range(0, 1));
            i_rx_data = 8'($urandom);
            i_tx_done = 1'($urandom_range(0, 1));
            tick();
        end
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        check("rst_A", {24'd0, o_alu_A}, 32'd0);
        check("rst_B", {24'd0, o_alu_B}, 32'd0);
        check("rst_Op", {26'd0, o_alu_Op}, 32'd0);
        check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
        check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_overrun", {31'd0, o_rx_overrun}, 32'd0);
        i_rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            do_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_op, vecs[i].exp_res);
            tick();
        end
        check("no_overrun_yet", {31'd0, o_rx_overrun}, 32'd0);

        // Overrun: byte arriving in WAIT_TX together with tx_done.
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h20);
        sb.push_back(8'h03);
        starts_exp++;
        tick();
        tick();
        i_rx_data = 8'h55;
        i_rx_done = 1'b1;
        i_tx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        check("ovr_flag", {31'd0, o_rx_overrun}, 32'd1);
        check("ovr_busy", {31'd0, o_busy}, 32'd0);
        check("ovr_A_kept", {24'd0, o_alu_A}, 32'h01);
        send_byte(8'h77);
        check("ovr_next_A", {24'd0, o_alu_A}, 32'h77);
        check("ovr_sticky", {31'd0, o_rx_overrun}, 32'd1);
        send_byte(8'h08);
        send_byte(8'h20);
        sb.push_back(8'h7F);
        starts_exp++;
        tick();
        tick();
        pulse_tx_done();
        check("ovr_sticky2", {31'd0, o_rx_overrun}, 32'd1);

        // Reset mid-sequence discards partial A/B.
        send_byte(8'h11);
        send_byte(8'h22);
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        check("mid_rst_A", {24'd0, o_alu_A}, 32'd0);
        check("mid_rst_B", {24'd0, o_alu_B}, 32'd0);
        check("mid_rst_overrun", {31'd0, o_rx_overrun}, 32'd0);
        do_txn(8'h05, 8'h01, 8'h25, 6'h25, 8'h05);

        // Spurious tx_done in WAIT_B must not move the FSM.
        send_byte(8'h40);
        pulse_tx_done();
        send_byte(8'h02);
        check("spur_A", {24'd0, o_alu_A}, 32'h40);
        check("spur_B", {24'd0, o_alu_B}, 32'h02);
        check("spur_busy", {31'd0, o_busy}, 32'd0);
        send_byte(8'hE0);
        sb.push_back(8'h42);
        starts_exp++;
        check("spur_Op_slice", {26'd0, o_alu_Op}, 32'h20);
        tick();
        tick();
        pulse_tx_done();
        tick();

        check("sb_drained", sb.size(), 32'd0);
        check("start_count", starts_seen, starts_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
